// File: rtl/servo_pkg.sv
// servo_pkg: types and default constants shared by the servo ramp generator
// and the servo pulse meter. Both count in 1-tick units of TICK_DIV clocks.
package servo_pkg;

    localparam int TICK_DIV        = 100;    // clocks per tick (1 us at 100 MHz)
    localparam int PERIOD_TICKS    = 20000;  // one servo frame in ticks
    localparam int WIDTH_MAX_TICKS = 2500;   // longest legal servo pulse in ticks

    typedef logic [14:0] tick_cnt_t;

    typedef enum logic [1:0] {
        S_WAIT_LOW,
        S_IDLE,
        S_HIGH
    } pm_state_t;

    // Increment that sticks at lim instead of wrapping.
    function automatic tick_cnt_t sat_inc(input tick_cnt_t v, input tick_cnt_t lim);
        return (v == lim) ? v : v + tick_cnt_t'(1);
    endfunction

endpackage

// File: rtl/servo_pulse_meter_sync_edge.sv
// sync_edge: brings an asynchronous pin into the clk domain through two flops
// and flags rise/fall in the same cycle the synchronized level changes.
module sync_edge (
    input  logic clk,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: these flops carry no reset so they keep tracking the pin while the
    // rest of the block is held in reset; a pin that is already high at reset
    // release then shows no false rise.
    // Two-stage synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        r_meta <= i_async;
        r_sync <= r_meta;
        r_prev <= r_sync;
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/servo_pulse_meter.sv
// servo_pulse_meter: measures the high time of a servo PWM input in ticks of
// TICK_DIV clocks, strobes each completed width, flags over-long pulses and
// reports loss of signal. Defining PULSE_METER_PERIOD_EN adds a rise-to-rise
// period measurement with its own output ports.
module servo_pulse_meter
    import servo_pkg::*;
#(
    parameter int TICK_DIV   = servo_pkg::TICK_DIV,
    parameter int WIDTH_MAX  = servo_pkg::WIDTH_MAX_TICKS,
    parameter int PERIOD_MAX = servo_pkg::PERIOD_TICKS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      pwm_in,
    output tick_cnt_t width,
    output logic      width_valid,
    output logic      err,
    output logic      signal_lost
`ifdef PULSE_METER_PERIOD_EN
    ,
    output tick_cnt_t period,
    output logic      period_valid
`endif
);

    localparam int                PRES_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRES_W-1:0] PRES_LAST = PRES_W'(TICK_DIV - 1);
    localparam tick_cnt_t         WIDTH_LIM = tick_cnt_t'(WIDTH_MAX);
    localparam tick_cnt_t         GAP_LIM   = tick_cnt_t'(PERIOD_MAX);

    logic              w_level;
    logic              w_rise;
    logic              w_fall;
    logic              w_tick;
    logic              w_capture;
    logic              w_err;
    logic [PRES_W-1:0] r_pres;
    pm_state_t         r_state;
    pm_state_t         w_state_nxt;
    tick_cnt_t         r_cnt;
    tick_cnt_t         r_gap;
    tick_cnt_t         r_width;
    logic              r_width_valid;
    logic              r_lost;

    sync_edge u_sync (
        .clk     (clk),
        .i_async (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_tick = (r_pres == PRES_LAST);

    // NOTE: every register below uses <= so all of them see the values from
    // before the clock edge, regardless of statement order.
    // Prescaler: realigned to each rise so the first tick lands TICK_DIV-1
    // cycles after it, which makes width = floor(high_clocks / TICK_DIV).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pres <= '0;
        end else if (w_rise) begin
            r_pres <= PRES_W'(1);
        end else if (w_tick) begin
            r_pres <= '0;
        end else begin
            r_pres <= r_pres + PRES_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_WAIT_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    // Next state plus capture/err decisions; a fall wins over a tick in the
    // same cycle, so a pulse ending on a tick is still reported as a width.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_WAIT_LOW: begin
                if (!w_level) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_rise) w_state_nxt = S_HIGH;
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tick && (r_cnt == WIDTH_LIM)) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_WAIT_LOW;
                end
            end
            default: w_state_nxt = S_WAIT_LOW;
        endcase
    end

    // Width counter, captured width, gap counter and loss-of-signal flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_gap         <= '0;
            r_width       <= '0;
            r_width_valid <= 1'b0;
            r_lost        <= 1'b1;
        end else begin
            if ((r_state == S_IDLE) && w_rise) begin
                r_cnt <= '0;
            end else if ((r_state == S_HIGH) && w_tick && !w_fall && (r_cnt != WIDTH_LIM)) begin
                r_cnt <= r_cnt + tick_cnt_t'(1);
            end

            if (w_capture) begin
                r_width <= r_cnt;
            end
            r_width_valid <= w_capture;

            if (w_rise) begin
                r_gap <= '0;
            end else if (w_tick) begin
                r_gap <= sat_inc(r_gap, GAP_LIM);
            end

            // Loss is declared on the tick that brings the gap to its limit.
            if (w_capture) begin
                r_lost <= 1'b0;
            end else if (w_tick && !w_rise && (r_gap == GAP_LIM - tick_cnt_t'(1))) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign width       = r_width;
    assign width_valid = r_width_valid;
    assign err         = w_err;
    assign signal_lost = r_lost;

`ifdef PULSE_METER_PERIOD_EN
    tick_cnt_t r_per_cnt;
    tick_cnt_t r_period;
    logic      r_period_valid;
    logic      r_armed;

    // Rise-to-rise tick counter. A period is reported only when the previous
    // rise is still trusted: an err, or silence running past the frame limit,
    // drops that trust until the next rise re-arms it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_per_cnt      <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (w_rise) begin
                r_per_cnt <= '0;
                r_armed   <= 1'b1;
                if (r_armed) begin
                    r_period       <= r_per_cnt;
                    r_period_valid <= 1'b1;
                end
            end else begin
                if (w_tick) begin
                    r_per_cnt <= sat_inc(r_per_cnt, GAP_LIM);
                end
                if (w_err || (w_tick && (r_gap == GAP_LIM))) begin
                    r_armed <= 1'b0;
                end
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
`else
    // Default build: no rise-to-rise measurement.
`endif

endmodule

// File: tb/tb_servo_pulse_meter.sv
// tb_servo_pulse_meter: scoreboard bench for servo_pulse_meter, run with a
// scaled-down tick (TICK_DIV=10, WIDTH_MAX=25, PERIOD_MAX=200) so each
// scenario takes a few hundred to a few thousand clocks.
module tb_servo_pulse_meter;
    import servo_pkg::*;

    localparam int TD        = 10;
    localparam int WM        = 25;
    localparam int PM        = 200;
    localparam int ERR_LAT   = (WM + 1) * TD - 1;  // rise cycle to err strobe
    localparam int MAX_CYCLE = 50000;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    logic      pwm_in = 1'b0;
    tick_cnt_t width;
    logic      width_valid;
    logic      err;
    logic      signal_lost;
`ifdef PULSE_METER_PERIOD_EN
    tick_cnt_t period;
    logic      period_valid;
`endif

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        bit is_err;
        int cyc;
        int val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
`ifdef PULSE_METER_PERIOD_EN
    exp_t per_q[$];
    exp_t mon_p;
    bit   tb_armed  = 1'b0;
    int   tb_last_n = 0;
`endif

    servo_pulse_meter #(
        .TICK_DIV   (TD),
        .WIDTH_MAX  (WM),
        .PERIOD_MAX (PM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .width        (width),
        .width_valid  (width_valid),
        .err          (err),
        .signal_lost  (signal_lost)
`ifdef PULSE_METER_PERIOD_EN
        ,
        .period       (period),
        .period_valid (period_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: every width_valid/err strobe must match the next queued
    // expectation in kind, cycle and value.
    always @(negedge clk) begin
        if (rst && (width_valid || err)) begin
            check("strobe_exclusive", int'(width_valid & err), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", int'({err, width_valid}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", int'({err, width_valid}), mon_e.is_err ? 2 : 1);
                check("strobe_cycle", cyc, mon_e.cyc);
                if (!mon_e.is_err) begin
                    check("width", int'(width), mon_e.val);
                    check("lost_on_valid", int'(signal_lost), 0);
                end
            end
        end
`ifdef PULSE_METER_PERIOD_EN
        if (rst && period_valid) begin
            if (per_q.size() == 0) begin
                check("unexpected_period", 1, 0);
            end else begin
                mon_p = per_q.pop_front();
                check("period_cycle", cyc, mon_p.cyc);
                check("period", int'(period), mon_p.val);
            end
        end
`endif
    end

    initial begin
        #(MAX_CYCLE * 10);
        $display("FAIL watchdog: observed cycle %0d, expected finish before %0d", cyc, MAX_CYCLE);
        $fatal(1, "bench timeout");
    end

    task automatic do_reset(input logic pin);
        rst    = 1'b0;
        pwm_in = pin;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_width", int'(width), 0);
        check("rst_width_valid", int'(width_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_signal_lost", int'(signal_lost), 1);
`ifdef PULSE_METER_PERIOD_EN
        check("rst_period", int'(period), 0);
        check("rst_period_valid", int'(period_valid), 0);
        tb_armed = 1'b0;
`endif
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One high pulse of 'high' clocks then 'low' clocks low. Queues the
    // expected strobe: width = floor(high/TD) three clocks after the pin
    // falls, or err ERR_LAT clocks after the synchronized rise (pin + 2).
    task automatic pulse(input int high, input int low, output int n_rise);
        exp_t e;
        @(posedge clk);
        #1 pwm_in = 1'b1;
        n_rise = cyc;
        if (high < (WM + 1) * TD) e = '{1'b0, cyc + high + 3, high / TD};
        else                      e = '{1'b1, cyc + 2 + ERR_LAT, 0};
        exp_q.push_back(e);
`ifdef PULSE_METER_PERIOD_EN
        if (tb_armed && ((n_rise - tb_last_n) / TD <= PM)) begin
            per_q.push_back('{1'b0, n_rise + 3, (n_rise - tb_last_n) / TD});
        end
        tb_armed  = !e.is_err;
        tb_last_n = n_rise;
`endif
        repeat (high) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (low) @(posedge clk);
    endtask

    initial begin
        int n;
        int highs[6] = '{9, 10, 19, 259, 260, 30};

        // Reset with the pin low, then one nominal pulse.
        do_reset(1'b0);
        pulse(150, 30, n);
        @(negedge clk);
        check("lost_after_valid", int'(signal_lost), 0);

        // Reset released with the pin high: that partial pulse is ignored.
        do_reset(1'b1);
        repeat (50) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (20) @(posedge clk);
        pulse(100, 30, n);

        // Rounding and the legal/over-long boundary, then recovery.
        for (int i = 0; i < 6; i++) pulse(highs[i], 30, n);
        pulse(300, 30, n);
        pulse(120, 0, n);

        // Loss of signal: set on the tick bringing the gap to PM ticks.
        while (cyc < n + 2001) @(negedge clk);
        check("lost_before_limit", int'(signal_lost), 0);
        @(negedge clk);
        check("lost_at_limit", int'(signal_lost), 1);
        pulse(50, 2100, n);

        // Frame-rate pulses; with the period option the 2nd and 3rd report PM.
        for (int i = 0; i < 3; i++) pulse(15, 1984, n);

        repeat (20) @(posedge clk);
        check("pending_strobes", exp_q.size(), 0);
`ifdef PULSE_METER_PERIOD_EN
        check("pending_periods", per_q.size(), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_pulse_meter.md
# servo_pulse_meter

Receive-side counterpart of the servo ramp generator: measures the high time of an incoming servo PWM signal in the same 1-tick units (TICK_DIV clocks) as the 0..20000 frame ramp. Reports each completed pulse width with a one-cycle valid strobe, flags over-long pulses, and detects loss of signal. It sits between an external pin (or loopback of our own PWM output) and the SPI/steering logic that reads back actual servo commands.

## Interface
- TICK_DIV, 100: clocks per tick; 1 µs at 100 MHz.
- WIDTH_MAX, 2500: largest legal width in ticks; 1 ≤ WIDTH_MAX < PERIOD_MAX.
- PERIOD_MAX, 20000: ticks without a rising edge before signal loss; ≤ 32767.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- pwm_in  in  1  asynchronous PWM input.
- width  out  15  last valid pulse width in ticks; holds until the next valid pulse.
- width_valid  out  1  one-cycle strobe when width updates.
- err  out  1  one-cycle strobe when a pulse exceeds WIDTH_MAX.
- signal_lost  out  1  level; no rising edge for PERIOD_MAX ticks.
- period, period_valid  out  15/1  only with PULSE_METER_PERIOD_EN; see Configuration.

## Operation
- Input path: 2-FF synchronizer, then an edge detector that produces rise/fall in the same cycle the synchronized level changes.
- Prescaler pres:
  - set to 1 on rise; otherwise increments.
  - tick when pres == TICK_DIV-1, then pres <= 0.
- States:
  - S_WAIT_LOW: entered from reset and after err. Moves to S_IDLE when the synchronized level is 0. Prevents measuring a partial pulse.
  - S_IDLE: on rise, clear cnt and go to S_HIGH.
  - S_HIGH:
    - each tick does cnt+1.
    - on fall: width <= cnt, width_valid, go to S_IDLE.
    - on a tick with cnt == WIDTH_MAX: err, go to S_WAIT_LOW, width unchanged.
- Fall has priority over a tick in the same cycle; that tick is not counted.
- Result: a synchronized high of H clocks gives width = floor(H/TICK_DIV), for H < (WIDTH_MAX+1)·TICK_DIV. Pulses shorter than TICK_DIV report width 0 with valid (not an error).
- Gap counter:
  - ticks in every state and saturates at PERIOD_MAX.
  - cleared on rise.
  - signal_lost sets when the gap counter reaches PERIOD_MAX and clears on the next width_valid.
- Counters are 15-bit unsigned with no wrap: cnt is bounded by WIDTH_MAX, the gap counter saturates.

## Timing
- Reset values:
  - width 0, width_valid 0, err 0, signal_lost 1, period 0, period_valid 0.
  - state S_WAIT_LOW, all counters 0.
- Reset asserted mid-pulse discards the pulse; outputs return to reset values the next cycle.
- Latency: pwm_in edge to synchronized edge is 2 cycles. width/width_valid are registered 1 cycle after the fall cycle, so 3 clocks from the pin's falling edge.
- err asserts (WIDTH_MAX+1)·TICK_DIV−1 cycles after the rise cycle.
- Strobes last exactly one cycle. width_valid and err never assert together.

## Configuration
- PULSE_METER_PERIOD_EN defined:
  - Adds ports period and period_valid, plus a rise-to-rise tick counter (15-bit, saturating at PERIOD_MAX).
  - On each rise that follows a previous rise seen without an intervening err or signal_lost, period <= counter and period_valid pulses 1 cycle after the rise cycle; the counter then clears.
- Undefined: the ports and logic are absent. All other behaviour is identical.

## Structure
- Package servo_pkg holds:
  - TICK_DIV and PERIOD_TICKS (20000) defaults, shared with the ramp counter.
  - Typedef pm_state_t {S_WAIT_LOW, S_IDLE, S_HIGH}.
  - Typedef tick_cnt_t = logic [14:0].
- Sub-module sync_edge: 2-FF synchronizer plus registered level, outputting level, rise and fall.

## Test plan
- Reset, pwm_in low; 150000-cycle high pulse → single width_valid, width=1500, 3 cycles after the pin falls; err=0.
- Release reset with pwm_in high for 50000 cycles, then low, then 100000 high → first pulse ignored, one width_valid with width=1000.
- High pulses of 99, 100 and 199 cycles → width 0, 1 and 1.
- 300000-cycle high → err pulse 250099 cycles after the rise cycle, no width_valid; next 120000-cycle pulse → width=1200.
- Idle low 2,000,000+ cycles → signal_lost=1 after 20000 ticks; next valid pulse clears it in the width_valid cycle.
- PULSE_METER_PERIOD_EN, 1.5 ms pulses every 2,000,000 cycles → period=20000, period_valid from the second rise onward.
